// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter that time-shares one external
// combinational ALU (behind a 2:1 operand/cntrl mux bank) between two
// requesters. The mux select is held for WAIT_CYCLES so the mux and ALU
// paths settle. The result and flags are then registered and returned on a
// single response channel.
//
// Handshake: a response transfers on a rising edge where rsp_valid && rsp_ready.
// Once rsp_valid is high, rsp_id/rsp_result/rsp_flags hold stable until that
// transfer. rsp_valid never drops without a transfer, except on reset.
// Requesters hold reqN_valid and their operands until the reqN_ack pulse.
module alu_share_arbiter #(
  parameter int WIDTH       = 64,
  parameter int WAIT_CYCLES = 2    // legal range 1..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ack,
  output logic             req1_ack,
  output logic             alu_sel,
  output logic             busy,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic             r_last_grant;
  logic             r_alu_sel;
  logic             r_busy;
  logic             r_req0_ack;
  logic             r_req1_ack;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;

  logic             w_any_valid;
  logic             w_grant;

  // Round-robin pick: a lone requester wins outright, a tie goes to the
  // requester that was not served last.
  always_comb begin
    w_any_valid = req0_valid | req1_valid;
    w_grant     = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = req1_valid;
    end
  end

  // Arbitration FSM with registered outputs; ack pulses self-clear each cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_alu_sel    <= 1'b0;
      r_busy       <= 1'b0;
      r_req0_ack   <= 1'b0;
      r_req1_ack   <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= 4'd0;
    end else begin
      r_req0_ack <= 1'b0;
      r_req1_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_alu_sel <= w_grant;
            r_cnt     <= CNT_INIT;
            r_busy    <= 1'b1;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          // alu_sel is deliberately untouched here so the mux path stays put.
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_result <= alu_result;
            r_rsp_flags  <= alu_flags;
            r_rsp_id     <= r_alu_sel;
            r_rsp_valid  <= 1'b1;
            r_req0_ack   <= ~r_alu_sel;
            r_req1_ack   <= r_alu_sel;
            r_last_grant <= r_alu_sel;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          // No arbitration here; a waiting requester is picked up in IDLE.
          if (r_rsp_valid && rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign req0_ack   = r_req0_ack;
  assign req1_ack   = r_req1_ack;
  assign alu_sel    = r_alu_sel;
  assign busy       = r_busy;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign dbg_state  = r_state;

endmodule
